// File: rtl/c3aibadapt_txclk_pkg.sv
// Shared definitions for the TX channel clock-gate enable sequencer:
// FSM state encoding and default counter widths.
package c3aibadapt_txclk_pkg;

    localparam int DEF_IDLE_CNT_W = 8;
    localparam int DEF_WAKE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } gate_state_t;

endpackage : c3aibadapt_txclk_pkg

// File: rtl/c3aibadapt_txclk_gate_ctl.sv
// Enable sequencer feeding the TX channel clock gate: wakes the gated clock on
// demand, waits a settle time before tx_ready, and gates it off after idling.
module c3aibadapt_txclk_gate_ctl
    import c3aibadapt_txclk_pkg::*;
#(
    parameter int IDLE_CNT_W = DEF_IDLE_CNT_W,
    parameter int WAKE_CNT_W = DEF_WAKE_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r_gate_bypass,
    input  logic [IDLE_CNT_W-1:0] r_idle_thresh,
    input  logic [WAKE_CNT_W-1:0] r_wake_dly,
    input  logic                  tx_req,
    input  logic                  tx_busy,
    input  logic                  scan_mode,
    output logic                  gate_e,
    output logic                  gate_te,
    output logic                  tx_ready,
    output logic [1:0]            gate_state
);

    gate_state_t           r_state;
    gate_state_t           w_state_nxt;
    logic                  r_gate_e;
    logic                  w_gate_e_nxt;
    logic                  r_tx_ready;
    logic                  w_tx_ready_nxt;
    logic [WAKE_CNT_W-1:0] r_wake_cnt;
    logic [WAKE_CNT_W-1:0] w_wake_cnt_nxt;
    logic [IDLE_CNT_W-1:0] r_idle_cnt;
    logic [IDLE_CNT_W-1:0] w_idle_cnt_nxt;

    logic w_active;
    logic w_wake_done;
    logic w_idle_done;

    // tx_busy alone cannot wake from OFF: the draining logic has no clock there.
    assign w_active    = tx_req | tx_busy | r_gate_bypass;
    assign w_wake_done = (r_wake_cnt >= r_wake_dly);
    assign w_idle_done = (r_idle_cnt >= r_idle_thresh);

    always_comb begin
        w_state_nxt    = r_state;
        w_gate_e_nxt   = r_gate_e;
        w_tx_ready_nxt = r_tx_ready;
        w_wake_cnt_nxt = r_wake_cnt;
        w_idle_cnt_nxt = r_idle_cnt;

        case (r_state)
            ST_OFF: begin
                w_gate_e_nxt   = 1'b0;
                w_tx_ready_nxt = 1'b0;
                if (tx_req | r_gate_bypass) begin
                    w_state_nxt    = ST_WAKE;
                    w_gate_e_nxt   = 1'b1;
                    w_wake_cnt_nxt = '0;
                end
            end
            ST_WAKE: begin
                w_gate_e_nxt   = 1'b1;
                w_tx_ready_nxt = 1'b0;
                if (!(&r_wake_cnt)) begin
                    w_wake_cnt_nxt = r_wake_cnt + 1'b1;
                end
                if (w_wake_done) begin
                    w_state_nxt    = ST_ON;
                    w_tx_ready_nxt = 1'b1;
                end
            end
            ST_ON: begin
                w_gate_e_nxt   = 1'b1;
                w_tx_ready_nxt = 1'b1;
                if (!w_active) begin
                    w_state_nxt    = ST_IDLE;
                    w_idle_cnt_nxt = '0;
                end
            end
            ST_IDLE: begin
                w_gate_e_nxt   = 1'b1;
                w_tx_ready_nxt = 1'b1;
                // Activity on the terminal-count cycle wins over gate-off.
                if (w_active) begin
                    w_state_nxt    = ST_ON;
                    w_idle_cnt_nxt = '0;
                end else if (w_idle_done) begin
                    w_state_nxt    = ST_OFF;
                    w_gate_e_nxt   = 1'b0;
                    w_tx_ready_nxt = 1'b0;
                end else if (!(&r_idle_cnt)) begin
                    w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = ST_OFF;
                w_gate_e_nxt   = 1'b0;
                w_tx_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_OFF;
            r_gate_e   <= 1'b0;
            r_tx_ready <= 1'b0;
            r_wake_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gate_e   <= w_gate_e_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_wake_cnt <= w_wake_cnt_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
        end
    end

    // Enables come straight from flops so the gate latch only sees post-edge changes.
    assign gate_e     = r_gate_e;
    assign tx_ready   = r_tx_ready;
    assign gate_te    = scan_mode;
    assign gate_state = r_state;

endmodule : c3aibadapt_txclk_gate_ctl

// File: tb/tb_c3aibadapt_txclk_gate_ctl.sv
// Directed bench for the TX clock-gate enable sequencer.
module tb_c3aibadapt_txclk_gate_ctl;

    logic       clk;
    logic       rst;
    logic       r_gate_bypass;
    logic [7:0] r_idle_thresh;
    logic [3:0] r_wake_dly;
    logic       tx_req;
    logic       tx_busy;
    logic       scan_mode;
    logic       gate_e;
    logic       gate_te;
    logic       tx_ready;
    logic [1:0] gate_state;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_WAKE = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd3;

    c3aibadapt_txclk_gate_ctl #(
        .IDLE_CNT_W(8),
        .WAKE_CNT_W(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .r_gate_bypass(r_gate_bypass),
        .r_idle_thresh(r_idle_thresh),
        .r_wake_dly   (r_wake_dly),
        .tx_req       (tx_req),
        .tx_busy      (tx_busy),
        .scan_mode    (scan_mode),
        .gate_e       (gate_e),
        .gate_te      (gate_te),
        .tx_ready     (tx_ready),
        .gate_state   (gate_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        r_gate_bypass = 1'b0;
        tx_req        = 1'b0;
        tx_busy       = 1'b0;
        scan_mode     = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    // Drives tx_req high from OFF and leaves it high once ON is reached.
    task automatic go_on(input logic [3:0] dly);
        r_wake_dly = dly;
        tx_req     = 1'b1;
        repeat (int'(dly) + 3) step();
        checks++;
        if (gate_state !== S_ON) begin
            failures++;
            $display("FAIL go_on_state actual=%0d required=%0d", gate_state, S_ON);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (gate_e !== 1'b0) begin failures++; $display("FAIL reset_gate_e actual=%0b required=0", gate_e); end
        checks++;
        if (tx_ready !== 1'b0) begin failures++; $display("FAIL reset_tx_ready actual=%0b required=0", tx_ready); end
        checks++;
        if (gate_state !== S_OFF) begin failures++; $display("FAIL reset_state actual=%0d required=0", gate_state); end
        rst = 1'b0;
        step();
        go_on(4'd0);
        // Assert reset between edges: outputs must drop with no clock.
        tx_req = 1'b0;
        rst    = 1'b1;
        #1;
        checks++;
        if (gate_e !== 1'b0) begin failures++; $display("FAIL async_rst_gate_e actual=%0b required=0", gate_e); end
        checks++;
        if (tx_ready !== 1'b0) begin failures++; $display("FAIL async_rst_tx_ready actual=%0b required=0", tx_ready); end
        checks++;
        if (gate_state !== S_OFF) begin failures++; $display("FAIL async_rst_state actual=%0d required=0", gate_state); end
        step();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (gate_state !== S_OFF || gate_e !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_stay_off actual=state%0d/e%0b required=state0/e0", gate_state, gate_e);
        end
    endtask

    task automatic test_wake_latency();
        logic [1:0] exp_state;
        do_reset();
        r_wake_dly    = 4'd3;
        r_idle_thresh = 8'd5;
        checks++;
        if (gate_e !== 1'b0) begin failures++; $display("FAIL wake_pre_gate_e actual=%0b required=0", gate_e); end
        tx_req = 1'b1;
        step();
        tx_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp_state = (k < 5) ? S_WAKE : S_ON;
            checks++;
            if (gate_e !== 1'b1) begin failures++; $display("FAIL wake_gate_e N+%0d actual=%0b required=1", k, gate_e); end
            checks++;
            if (tx_ready !== (k == 5)) begin
                failures++;
                $display("FAIL wake_tx_ready N+%0d actual=%0b required=%0b", k, tx_ready, (k == 5));
            end
            checks++;
            if (gate_state !== exp_state) begin
                failures++;
                $display("FAIL wake_state N+%0d actual=%0d required=%0d", k, gate_state, exp_state);
            end
            if (k < 5) step();
        end
    endtask

    task automatic test_idle_gateoff();
        logic       exp_on;
        logic [1:0] exp_state;
        do_reset();
        r_idle_thresh = 8'd5;
        go_on(4'd0);
        tx_req  = 1'b0;
        tx_busy = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_on    = (k <= 6);
            exp_state = exp_on ? S_IDLE : S_OFF;
            checks++;
            if (gate_state !== exp_state) begin
                failures++;
                $display("FAIL idle_state M+%0d actual=%0d required=%0d", k, gate_state, exp_state);
            end
            checks++;
            if (gate_e !== exp_on || tx_ready !== exp_on) begin
                failures++;
                $display("FAIL idle_outputs M+%0d actual=e%0b/rdy%0b required=e%0b/rdy%0b",
                         k, gate_e, tx_ready, exp_on, exp_on);
            end
        end
    endtask

    task automatic test_reactivation_race();
        do_reset();
        r_idle_thresh = 8'd4;
        go_on(4'd0);
        tx_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (gate_e !== 1'b1) begin failures++; $display("FAIL race_gate_e M+%0d actual=%0b required=1", k, gate_e); end
            if (k == 5) begin
                checks++;
                if (gate_state !== S_IDLE) begin
                    failures++;
                    $display("FAIL race_terminal_state actual=%0d required=%0d", gate_state, S_IDLE);
                end
                tx_req = 1'b1;
            end
            if (k >= 6) begin
                checks++;
                if (gate_state !== S_ON) begin
                    failures++;
                    $display("FAIL race_state M+%0d actual=%0d required=%0d", k, gate_state, S_ON);
                end
            end
        end
    endtask

    task automatic test_busy_hold();
        do_reset();
        r_idle_thresh = 8'd4;
        go_on(4'd0);
        tx_req  = 1'b0;
        tx_busy = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            checks++;
            if (gate_state !== S_ON || tx_ready !== 1'b1) begin
                failures++;
                $display("FAIL busy_hold cyc%0d actual=state%0d/rdy%0b required=state2/rdy1", k, gate_state, tx_ready);
            end
        end
        tx_busy = 1'b0;
        step();
        checks++;
        if (gate_state !== S_IDLE) begin failures++; $display("FAIL busy_release_state actual=%0d required=%0d", gate_state, S_IDLE); end
        repeat (5) step();
        checks++;
        if (gate_state !== S_OFF) begin failures++; $display("FAIL busy_gateoff_state actual=%0d required=%0d", gate_state, S_OFF); end
        tx_busy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (gate_state !== S_OFF || gate_e !== 1'b0) begin
                failures++;
                $display("FAIL busy_no_wake cyc%0d actual=state%0d/e%0b required=state0/e0", k, gate_state, gate_e);
            end
        end
        tx_busy = 1'b0;
    endtask

    task automatic test_zero_cfg();
        do_reset();
        r_wake_dly    = 4'd0;
        r_idle_thresh = 8'd0;
        tx_req        = 1'b1;
        step();
        tx_req = 1'b0;
        checks++;
        if (gate_state !== S_WAKE || gate_e !== 1'b1 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_wake actual=state%0d/e%0b/rdy%0b required=state1/e1/rdy0", gate_state, gate_e, tx_ready);
        end
        step();
        checks++;
        if (gate_state !== S_ON || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_on actual=state%0d/rdy%0b required=state2/rdy1", gate_state, tx_ready);
        end
        step();
        checks++;
        if (gate_state !== S_IDLE || gate_e !== 1'b1) begin
            failures++;
            $display("FAIL zero_idle actual=state%0d/e%0b required=state3/e1", gate_state, gate_e);
        end
        step();
        checks++;
        if (gate_state !== S_OFF || gate_e !== 1'b0 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_off actual=state%0d/e%0b/rdy%0b required=state0/e0/rdy0", gate_state, gate_e, tx_ready);
        end
    endtask

    task automatic test_bypass_scan();
        logic [1:0] exp_state;
        rst           = 1'b1;
        r_gate_bypass = 1'b1;
        r_wake_dly    = 4'd2;
        r_idle_thresh = 8'd3;
        tx_req        = 1'b0;
        tx_busy       = 1'b0;
        scan_mode     = 1'b0;
        step();
        checks++;
        if (gate_state !== S_OFF) begin failures++; $display("FAIL bypass_in_reset actual=%0d required=0", gate_state); end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_state = (k < 4) ? S_WAKE : S_ON;
            checks++;
            if (gate_state !== exp_state) begin
                failures++;
                $display("FAIL bypass_wake cyc%0d actual=%0d required=%0d", k, gate_state, exp_state);
            end
        end
        for (int k = 1; k <= 1000; k++) begin
            step();
            checks++;
            if (gate_state !== S_ON || tx_ready !== 1'b1 || gate_e !== 1'b1) begin
                failures++;
                $display("FAIL bypass_hold cyc%0d actual=state%0d/e%0b/rdy%0b required=state2/e1/rdy1",
                         k, gate_state, gate_e, tx_ready);
            end
        end
        scan_mode = 1'b1;
        #1;
        checks++;
        if (gate_te !== 1'b1) begin failures++; $display("FAIL scan_te_high actual=%0b required=1", gate_te); end
        step();
        checks++;
        if (gate_state !== S_ON) begin failures++; $display("FAIL scan_state actual=%0d required=%0d", gate_state, S_ON); end
        scan_mode = 1'b0;
        #1;
        checks++;
        if (gate_te !== 1'b0) begin failures++; $display("FAIL scan_te_low actual=%0b required=0", gate_te); end
        step();
        r_gate_bypass = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        r_gate_bypass = 1'b0;
        r_idle_thresh = 8'd5;
        r_wake_dly    = 4'd0;
        tx_req        = 1'b0;
        tx_busy       = 1'b0;
        scan_mode     = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();

        test_reset();
        test_wake_latency();
        test_idle_gateoff();
        test_reactivation_race();
        test_busy_hold();
        test_zero_cfg();
        test_bypass_scan();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_c3aibadapt_txclk_gate_ctl
